// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the wait-state memory responder.
package mem_resp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [31:0] STATS_ACC_ADDR = 32'hFFFF_FF00;
   localparam logic [31:0] STATS_WR_ADDR  = 32'hFFFF_FF04;
   localparam int          LANES          = 4;

   // Word-aligned and inside the 4*2**addr_w byte window.
   function automatic logic addr_ok(input logic [31:0] addr, input int addr_w);
      logic [31:0] hi;
      hi = addr >> (addr_w + 2);
      return (addr[1:0] == 2'b00) && (hi == 32'd0);
   endfunction

endpackage

// File: rtl/mem_bank_be.sv
// Word array with per-byte-lane synchronous write and a registered read port.
module mem_bank_be
   import mem_resp_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              we,
   input  logic [LANES-1:0]  be,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   // NOTE: the array and its read register have no reset; a reset branch
   // would turn the RAM into a bank of flops. The top masks stale rdata.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < LANES; i++) begin
            if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/mem_resp_wait.sv
// Valid/ready memory responder with LAT wait states before each response.
// Optional MEM_STATS_EN adds accept/write counters readable at fixed addresses.
module mem_resp_wait
   import mem_resp_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int LAT    = 2,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [31:0]       req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [LANES-1:0]  req_be,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err
);

   localparam logic [3:0] LAT_C = 4'(LAT);

   state_t            state;
   logic [3:0]        cnt;
   logic              cap_we;
   logic [31:0]       cap_addr;
   logic              rsp_mem;
   logic [DATA_W-1:0] rsp_aux;
   logic [DATA_W-1:0] bank_rdata;

   logic              accept;
   logic              cur_we;
   logic [31:0]       cur_addr;
   logic              cur_stats;
   logic              cur_err;
   logic              enter_resp;
   logic              mem_we;
   logic              mem_re;
   logic [DATA_W-1:0] aux_val;

   assign req_ready = (state == IDLE) && !rst;
   assign accept    = req_valid && req_ready;

   // With LAT==0 the response is built on the accept edge from the live
   // request; otherwise from the copy captured at accept.
   assign cur_we   = (state == IDLE) ? req_we   : cap_we;
   assign cur_addr = (state == IDLE) ? req_addr : cap_addr;

   assign enter_resp = ((state == IDLE) && accept && (LAT == 0)) ||
                       ((state == WAIT) && (cnt == LAT_C));

   assign cur_err = !addr_ok(cur_addr, ADDR_W) && !cur_stats;
   assign mem_we  = accept && req_we && addr_ok(req_addr, ADDR_W);
   assign mem_re  = enter_resp && !cur_err && !cur_we && !cur_stats;

`ifdef MEM_STATS_EN
   logic [31:0] acc_cnt;
   logic [31:0] wr_cnt;
   logic [31:0] acc_nxt;

   // acc_nxt lets a LAT==0 stats read see its own accept.
   assign acc_nxt   = acc_cnt + 32'(accept);
   assign cur_stats = !cur_we && ((cur_addr == STATS_ACC_ADDR) ||
                                  (cur_addr == STATS_WR_ADDR));
   assign aux_val   = (cur_addr == STATS_WR_ADDR) ? wr_cnt : acc_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_cnt <= 32'd0;
         wr_cnt  <= 32'd0;
      end else begin
         acc_cnt <= acc_nxt;
         if (mem_we) wr_cnt <= wr_cnt + 32'd1;
      end
   end
`else
   assign cur_stats = 1'b0;
   assign aux_val   = '0;
`endif

   mem_bank_be #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_bank (
      .clk   (clk),
      .we    (mem_we),
      .be    (req_be),
      .waddr (req_addr[ADDR_W+1:2]),
      .wdata (req_wdata),
      .re    (mem_re),
      .raddr (cur_addr[ADDR_W+1:2]),
      .rdata (bank_rdata)
   );

   assign rsp_rdata = rsp_mem ? bank_rdata : rsp_aux;

   // NOTE: all state here uses <= so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         cap_we    <= 1'b0;
         cap_addr  <= 32'd0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_mem   <= 1'b0;
         rsp_aux   <= '0;
      end else begin
         rsp_valid <= 1'b0;
         if (enter_resp) begin
            rsp_valid <= 1'b1;
            rsp_err   <= cur_err;
            rsp_mem   <= mem_re;
            rsp_aux   <= cur_stats ? aux_val : '0;
         end
         case (state)
            IDLE: begin
               if (accept) begin
                  cap_we   <= req_we;
                  cap_addr <= req_addr;
                  if (LAT == 0) begin
                     state <= RESP;
                  end else begin
                     state <= WAIT;
                     cnt   <= 4'd1;
                  end
               end
            end
            WAIT: begin
               if (cnt == LAT_C) begin
                  state <= RESP;
                  cnt   <= 4'd0;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_resp_wait.sv
// Directed bench: LAT=2 instance (index 0) and LAT=0 instance (index 1).
module tb_mem_resp_wait;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid [2];
   logic        req_ready [2];
   logic        req_we    [2];
   logic [31:0] req_addr  [2];
   logic [31:0] req_wdata [2];
   logic [3:0]  req_be    [2];
   logic        rsp_valid [2];
   logic [31:0] rsp_rdata [2];
   logic        rsp_err   [2];

   int n_cmp = 0;
   int n_mis = 0;

   always #5 clk = ~clk;

   mem_resp_wait #(.ADDR_W(10), .LAT(2), .DATA_W(32)) u_dut (
      .clk (clk), .rst (rst),
      .req_valid (req_valid[0]), .req_ready (req_ready[0]), .req_we (req_we[0]),
      .req_addr (req_addr[0]), .req_wdata (req_wdata[0]), .req_be (req_be[0]),
      .rsp_valid (rsp_valid[0]), .rsp_rdata (rsp_rdata[0]), .rsp_err (rsp_err[0])
   );

   mem_resp_wait #(.ADDR_W(10), .LAT(0), .DATA_W(32)) u_dut0 (
      .clk (clk), .rst (rst),
      .req_valid (req_valid[1]), .req_ready (req_ready[1]), .req_we (req_we[1]),
      .req_addr (req_addr[1]), .req_wdata (req_wdata[1]), .req_be (req_be[1]),
      .rsp_valid (rsp_valid[1]), .rsp_rdata (rsp_rdata[1]), .rsp_err (rsp_err[1])
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One full transaction: wait ready, accept, scramble inputs, time the response.
   task automatic txn(input int d, input logic we, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [3:0] be,
                      input logic [31:0] exp_rd, input logic exp_err, input string tag);
      int n;
      int exp_lat;
      exp_lat = (d == 0) ? 3 : 1;
      n = 0;
      while (!req_ready[d] && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({tag, "/ready"}, 32'(req_ready[d]), 32'd1);
      req_valid[d] = 1'b1;
      req_we[d]    = we;
      req_addr[d]  = addr;
      req_wdata[d] = wd;
      req_be[d]    = be;
      @(posedge clk);
      #1;
      req_valid[d] = 1'b0;
      req_we[d]    = ~we;
      req_addr[d]  = ~addr;
      req_wdata[d] = ~wd;
      req_be[d]    = 4'hF;
      for (n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (rsp_valid[d]) break;
      end
      check({tag, "/lat"}, 32'(n), 32'(exp_lat));
      check({tag, "/rdata"}, rsp_rdata[d], exp_rd);
      check({tag, "/err"}, 32'(rsp_err[d]), 32'(exp_err));
      @(negedge clk);
      check({tag, "/pulse"}, 32'(rsp_valid[d]), 32'd0);
      check({tag, "/hold"}, rsp_rdata[d], exp_rd);
   endtask

   initial begin
      int seen;
      for (int i = 0; i < 2; i++) begin
         req_valid[i] = 1'b0;
         req_we[i]    = 1'b0;
         req_addr[i]  = 32'd0;
         req_wdata[i] = 32'd0;
         req_be[i]    = 4'h0;
      end

      // Reset behaviour
      repeat (3) @(negedge clk);
      check("rst/ready0", 32'(req_ready[0]), 32'd0);
      check("rst/ready1", 32'(req_ready[1]), 32'd0);
      check("rst/valid", 32'(rsp_valid[0]), 32'd0);
      check("rst/rdata", rsp_rdata[0], 32'd0);
      check("rst/err", 32'(rsp_err[0]), 32'd0);
      rst = 1'b0;
      #1;
      check("post_rst/ready0", 32'(req_ready[0]), 32'd1);
      check("post_rst/ready1", 32'(req_ready[1]), 32'd1);

      // Statistics sequence straight after reset: 3 writes (one misaligned), 1 read
      txn(0, 1'b1, 32'h20, 32'hA5A5_0001, 4'hF, 32'd0, 1'b0, "st_w0");
      txn(0, 1'b1, 32'h22, 32'h0000_0BAD, 4'hF, 32'd0, 1'b1, "st_wmis");
      txn(0, 1'b1, 32'h24, 32'hA5A5_0002, 4'hF, 32'd0, 1'b0, "st_w1");
      txn(0, 1'b0, 32'h20, 32'd0, 4'hF, 32'hA5A5_0001, 1'b0, "st_rd");
`ifdef MEM_STATS_EN
      txn(0, 1'b0, 32'hFFFF_FF00, 32'd0, 4'hF, 32'd5, 1'b0, "st_acc");
      txn(0, 1'b0, 32'hFFFF_FF04, 32'd0, 4'hF, 32'd2, 1'b0, "st_wr");
      txn(0, 1'b1, 32'hFFFF_FF00, 32'h1, 4'hF, 32'd0, 1'b1, "st_wrerr");
`else
      txn(0, 1'b0, 32'hFFFF_FF00, 32'd0, 4'hF, 32'd0, 1'b1, "st_acc_off");
`endif

      // Full write, read back, partial write, error cases
      txn(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'd0, 1'b0, "w_full");
      txn(0, 1'b0, 32'h10, 32'd0, 4'hF, 32'hDEAD_BEEF, 1'b0, "r_full");
      txn(0, 1'b1, 32'h10, 32'h1122_3344, 4'b0101, 32'd0, 1'b0, "w_part");
      txn(0, 1'b0, 32'h10, 32'd0, 4'hF, 32'hDE22_BE44, 1'b0, "r_part");
      txn(0, 1'b1, 32'h10, 32'h0000_0000, 4'b0000, 32'd0, 1'b0, "w_be0");
      txn(0, 1'b0, 32'h10, 32'd0, 4'hF, 32'hDE22_BE44, 1'b0, "r_be0");
      txn(0, 1'b0, 32'h12, 32'd0, 4'hF, 32'd0, 1'b1, "r_mis");
      txn(0, 1'b0, 32'h1000, 32'd0, 4'hF, 32'd0, 1'b1, "r_oor");
      txn(0, 1'b0, 32'h10, 32'd0, 4'hF, 32'hDE22_BE44, 1'b0, "r_after_err");

      // Reset during the WAIT cycle of a read: no response ever appears
      req_valid[0] = 1'b1;
      req_we[0]    = 1'b0;
      req_addr[0]  = 32'h10;
      @(posedge clk);
      #1;
      req_valid[0] = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (rsp_valid[0]) seen++;
      end
      check("midrst/no_rsp", 32'(seen), 32'd0);
      check("midrst/rdata", rsp_rdata[0], 32'd0);

      // Reset after a write was accepted: the write stays committed
      req_valid[0] = 1'b1;
      req_we[0]    = 1'b1;
      req_addr[0]  = 32'h30;
      req_wdata[0] = 32'h0BAD_CAFE;
      req_be[0]    = 4'hF;
      @(posedge clk);
      #1;
      req_valid[0] = 1'b0;
      req_we[0]    = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      txn(0, 1'b0, 32'h30, 32'd0, 4'hF, 32'h0BAD_CAFE, 1'b0, "midrst_w");

      // LAT=0 instance
      txn(1, 1'b1, 32'h40, 32'hCAFE_F00D, 4'hF, 32'd0, 1'b0, "l0_w");
      txn(1, 1'b0, 32'h40, 32'd0, 4'hF, 32'hCAFE_F00D, 1'b0, "l0_r");

      // Back-to-back reads with valid held high: accepted every 2 cycles
      req_valid[1] = 1'b1;
      req_we[1]    = 1'b0;
      req_addr[1]  = 32'h40;
      for (int i = 0; i < 6; i++) begin
         check($sformatf("b2b/ready%0d", i), 32'(req_ready[1]), 32'((i % 2) == 0));
         check($sformatf("b2b/valid%0d", i), 32'(rsp_valid[1]), 32'((i % 2) == 1));
         @(negedge clk);
      end
      req_valid[1] = 1'b0;
      check("b2b/rdata", rsp_rdata[1], 32'hCAFE_F00D);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/mem_resp_wait.md
Name: mem_resp_wait

Overview:
- Memory-side responder for the multicycle MIPS data/instruction port.
- Accepts CPU requests over a valid/ready handshake and returns responses after a configurable number of wait states.
- Backed by a byte-lane-writable word array.
- Replaces the zero-latency memory model so stall and handshake handling in the CPU FSM can be exercised.

Parameters:
- ADDR_W, 10, word-address bits; depth = 2**ADDR_W words (byte space 0x0000_0000 .. 4*2**ADDR_W-1)
- LAT, 2, wait cycles between accept and response (0..15)
- DATA_W, 32, data width; fixed at 32, byte lanes = DATA_W/8

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  CPU request present
- req_ready  out  1  responder can accept a request
- req_we  in  1  1 = write, 0 = read
- req_addr  in  32  byte address
- req_wdata  in  32  write data
- req_be  in  4  byte enables, bit i = byte lane [8i+7:8i]
- rsp_valid  out  1  one-cycle response strobe
- rsp_rdata  out  32  read data; 0 for writes and errors
- rsp_err  out  1  request rejected (misaligned / out of range), valid with rsp_valid

Behaviour:
- Reset (sampled on clk while rst=1):
  - state=IDLE, wait counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - req_ready=0 while rst=1; req_ready=1 in the first cycle after rst falls.
  - Array contents are not reset.
- Handshake:
  - req_ready = (state==IDLE) && !rst.
  - A request is accepted on a rising edge with req_valid && req_ready.
  - req_* are sampled at accept only; later changes are ignored.
- FSM:
  - IDLE -> WAIT on accept if LAT>0; IDLE -> RESP on accept if LAT==0.
  - WAIT counts 1..LAT; exits to RESP on the edge where count==LAT.
  - RESP asserts rsp_valid for exactly one cycle, then returns to IDLE.
  - No backpressure on the response.
- Latency: rsp_valid goes high LAT+1 cycles after the accept edge. Minimum request spacing is LAT+2 cycles.
- Errors:
  - Error condition: addr[1:0]!=0, or any bit of addr[31:ADDR_W+2] set.
  - On error: rsp_err=1, rsp_rdata=0, no array write, same latency as a good request.
- Writes:
  - The array is updated on the accept edge, only on lanes with req_be[i]=1.
  - be=4'b0000 is a no-op with rsp_err=0.
- Reads:
  - Data is sampled from the array on the edge entering RESP.
  - A read issued after a write to the same word returns the new data.
- Hold behaviour: rsp_rdata and rsp_err hold their last response values until the next RESP. rsp_valid alone marks a new response.
- Reset mid-operation:
  - The transaction is abandoned and no response is issued.
  - A write that was already accepted remains committed.
- req_valid while not ready: ignored; the CPU must hold it until accepted.

Optional Feature:
- MEM_STATS_EN defined:
  - Two 32-bit counters, cleared by rst:
    - acc_cnt increments on every accepted request.
    - wr_cnt increments on every accepted non-error write.
  - Reads at 0xFFFF_FF00 return acc_cnt and reads at 0xFFFF_FF04 return wr_cnt, both with rsp_err=0.
  - The count returned by the stats read includes the stats read itself.
  - Writes to these addresses raise rsp_err=1.
- MEM_STATS_EN undefined: no counters; these addresses fall under the normal out-of-range error rule.

Decomposition:
- Package mem_resp_pkg:
  - state encoding IDLE/WAIT/RESP (2-bit)
  - STATS_ACC_ADDR=32'hFFFF_FF00 and STATS_WR_ADDR=32'hFFFF_FF04
  - lane count constant
  - address-check function (aligned && in-range)
- Sub-module mem_bank_be:
  - 2**ADDR_W x 32 array
  - synchronous byte-enable write and registered read port
  - instantiated once

Test Plan:
- LAT=2, after reset: req_ready=0 during rst, 1 the cycle after; rsp_valid=0, rsp_rdata=0.
- Write 0x0000_0010 data 0xDEAD_BEEF be=4'hF, then read 0x10 -> rsp_valid exactly 3 cycles after each accept, read returns 0xDEAD_BEEF, rsp_err=0.
- Partial write be=4'b0101, data 0x1122_3344 to 0x10 (prior 0xDEAD_BEEF) -> read returns 0xDE22_BE44.
- Read 0x0000_0012 (misaligned) and 0x0000_1000 (out of range for ADDR_W=10) -> rsp_err=1, rsp_rdata=0; a following read of 0x10 still returns the prior value.
- Assert rst in the WAIT cycle of a read -> no rsp_valid. Repeat with LAT=0: rsp_valid 1 cycle after accept, back-to-back requests accepted every 2 cycles.
- MEM_STATS_EN: after 3 accepted writes (one misaligned) and 1 read, a read of 0xFFFF_FF00 returns 5 and a read of 0xFFFF_FF04 returns 2. Without the macro, the same read gives rsp_err=1.
